// File: rtl/rename_regfile_mp.sv
// rename_regfile_mp: architectural register file with rename tag / busy
// tracking for a Tomasulo/ROB out-of-order core.
//  - NUM_READ combinational operand lookups with same-cycle commit bypass.
//  - One rename and NUM_COMMIT in-order commits per cycle; clear flushes rename state.
//  - Optional feature macro RRF_CKPT_EN: CKPT_DEPTH snapshots of tags/busy
//    that can be saved and restored; without it the ckpt_* inputs are ignored.
module rename_regfile_mp #(
  parameter int NUM_REGS   = 32,
  parameter int REG_W      = 5,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 4,
  parameter int NUM_READ   = 2,
  parameter int NUM_COMMIT = 2,
  parameter int CKPT_DEPTH = 4,
  parameter int CKPT_ID_W  = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         clear,
  input  logic [NUM_READ-1:0]          rd_valid,
  input  logic [NUM_READ*REG_W-1:0]    rd_addr,
  output logic [NUM_READ-1:0]          rd_ready,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [NUM_READ*TAG_W-1:0]    rd_tag,
  input  logic                         ren_valid,
  input  logic [REG_W-1:0]             ren_addr,
  input  logic [TAG_W-1:0]             ren_tag,
  input  logic [NUM_COMMIT-1:0]        cmt_valid,
  input  logic [NUM_COMMIT*REG_W-1:0]  cmt_addr,
  input  logic [NUM_COMMIT*TAG_W-1:0]  cmt_tag,
  input  logic [NUM_COMMIT*DATA_W-1:0] cmt_data,
  input  logic                         ckpt_save,
  input  logic [CKPT_ID_W-1:0]         ckpt_save_id,
  input  logic                         ckpt_restore,
  input  logic [CKPT_ID_W-1:0]         ckpt_restore_id
);

  // Architectural state. Reads are asynchronous, so this is a flop array.
  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [TAG_W-1:0]    tags_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;

  logic [DATA_W-1:0]   regs_next [NUM_REGS];
  logic [TAG_W-1:0]    tags_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;

`ifdef RRF_CKPT_EN
  // Snapshot slots: tags and busy only; data is architectural and never rolled back.
  logic [TAG_W-1:0]    ckpt_tags_reg  [CKPT_DEPTH][NUM_REGS];
  logic [NUM_REGS-1:0] ckpt_busy_reg  [CKPT_DEPTH];
  logic [TAG_W-1:0]    ckpt_tags_next [CKPT_DEPTH][NUM_REGS];
  logic [NUM_REGS-1:0] ckpt_busy_next [CKPT_DEPTH];
  // Slot busy bits after this cycle's commits have retired matching tags.
  logic [NUM_REGS-1:0] ckpt_busy_clr  [CKPT_DEPTH];
`else
  logic unused_ckpt;
  assign unused_ckpt = ^{ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id};
`endif

  // ---------------------------------------------------------------------
  // Read ports: zero-latency lookup with commit bypass.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [REG_W-1:0]  addr;
      logic              ready;
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
      logic              hit;
      logic [DATA_W-1:0] hit_data;

      assign addr = rd_addr[gi*REG_W +: REG_W];

      // Resolve one operand; the highest-index matching commit supplies the bypass value.
      always_comb begin
        ready    = 1'b0;
        data     = '0;
        tag      = '0;
        hit      = 1'b0;
        hit_data = '0;
        for (int c = 0; c < NUM_COMMIT; c++) begin
          if (cmt_valid[c] && (cmt_addr[c*REG_W +: REG_W] == addr) &&
              (cmt_tag[c*TAG_W +: TAG_W] == tags_reg[addr])) begin
            hit      = 1'b1;
            hit_data = cmt_data[c*DATA_W +: DATA_W];
          end
        end
        if (!rst && rd_valid[gi]) begin
          if (addr == '0) begin
            ready = 1'b1;
          end else if (hit) begin
            ready = 1'b1;
            data  = hit_data;
          end else begin
            ready = ~busy_reg[addr];
            data  = regs_reg[addr];
            tag   = tags_reg[addr];
          end
        end
      end

      assign rd_ready[gi]                  = ready;
      assign rd_data[gi*DATA_W +: DATA_W]  = data;
      assign rd_tag[gi*TAG_W +: TAG_W]     = tag;
    end
  endgenerate

`ifdef RRF_CKPT_EN
  // Commits retire their tag in every snapshot as well as in the live state.
  always_comb begin
    for (int s = 0; s < CKPT_DEPTH; s++) begin
      ckpt_busy_clr[s] = ckpt_busy_reg[s];
      for (int c = 0; c < NUM_COMMIT; c++) begin
        if (cmt_valid[c] && (cmt_addr[c*REG_W +: REG_W] != '0) &&
            (ckpt_tags_reg[s][cmt_addr[c*REG_W +: REG_W]] == cmt_tag[c*TAG_W +: TAG_W])) begin
          ckpt_busy_clr[s][cmt_addr[c*REG_W +: REG_W]] = 1'b0;
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Next architectural state: commits, then clear / restore / rename.
  // ---------------------------------------------------------------------
  always_comb begin
    regs_next = regs_reg;
    tags_next = tags_reg;
    busy_next = busy_reg;

    // Later ports overwrite earlier ones, so the highest index wins a collision.
    // The busy decision compares against the pre-edge tag only.
    for (int c = 0; c < NUM_COMMIT; c++) begin
      if (cmt_valid[c] && (cmt_addr[c*REG_W +: REG_W] != '0)) begin
        regs_next[cmt_addr[c*REG_W +: REG_W]] = cmt_data[c*DATA_W +: DATA_W];
        if (cmt_tag[c*TAG_W +: TAG_W] == tags_reg[cmt_addr[c*REG_W +: REG_W]])
          busy_next[cmt_addr[c*REG_W +: REG_W]] = 1'b0;
        else
          busy_next[cmt_addr[c*REG_W +: REG_W]] = busy_reg[cmt_addr[c*REG_W +: REG_W]];
      end
    end

    if (clear) begin
      // Flush: register values keep any same-cycle commit, rename is dropped.
      for (int i = 0; i < NUM_REGS; i++) tags_next[i] = '0;
      busy_next = '0;
`ifdef RRF_CKPT_EN
    end else if (ckpt_restore) begin
      // Restored slot already has this cycle's commit clears applied.
      tags_next = ckpt_tags_reg[ckpt_restore_id];
      busy_next = ckpt_busy_clr[ckpt_restore_id];
`endif
    end else if (ren_valid && (ren_addr != '0)) begin
      // Rename wins over a same-cycle busy clear on the same register.
      tags_next[ren_addr] = ren_tag;
      busy_next[ren_addr] = 1'b1;
    end

    // Register 0 is hardwired: never written, never busy.
    regs_next[0] = '0;
    tags_next[0] = '0;
    busy_next[0] = 1'b0;
  end

`ifdef RRF_CKPT_EN
  // Save captures the post-edge state (after rename, commit or restore); clear suppresses it.
  always_comb begin
    ckpt_tags_next = ckpt_tags_reg;
    ckpt_busy_next = ckpt_busy_clr;
    if (!clear && ckpt_save) begin
      ckpt_tags_next[ckpt_save_id] = tags_next;
      ckpt_busy_next[ckpt_save_id] = busy_next;
    end
  end

  // Snapshot slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        for (int i = 0; i < NUM_REGS; i++) ckpt_tags_reg[s][i] <= '0;
        ckpt_busy_reg[s] <= '0;
      end
    end else if (rdy) begin
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        for (int i = 0; i < NUM_REGS; i++) ckpt_tags_reg[s][i] <= ckpt_tags_next[s][i];
        ckpt_busy_reg[s] <= ckpt_busy_next[s];
      end
    end
  end
`endif

  // Architectural state registers; rdy low freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
        tags_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else if (rdy) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= regs_next[i];
        tags_reg[i] <= tags_next[i];
      end
      busy_reg <= busy_next;
    end
  end

endmodule

// File: tb/tb_rename_regfile_mp.sv
// Directed, table-driven bench for rename_regfile_mp (default parameters).
// Each vector is one clock: inputs are driven on the falling edge, the
// combinational read ports are compared 1 time unit later, and the state
// update happens on the following rising edge.
module tb_rename_regfile_mp;

  localparam int NR = 2;
  localparam int NC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          clear;
  logic [1:0]    rd_valid;
  logic [9:0]    rd_addr;
  logic [1:0]    rd_ready;
  logic [63:0]   rd_data;
  logic [7:0]    rd_tag;
  logic          ren_valid;
  logic [4:0]    ren_addr;
  logic [3:0]    ren_tag;
  logic [1:0]    cmt_valid;
  logic [9:0]    cmt_addr;
  logic [7:0]    cmt_tag;
  logic [63:0]   cmt_data;
  logic          ckpt_save;
  logic [1:0]    ckpt_save_id;
  logic          ckpt_restore;
  logic [1:0]    ckpt_restore_id;

  int checks   = 0;
  int failures = 0;

  rename_regfile_mp dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_tag(rd_tag),
    .ren_valid(ren_valid), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .cmt_valid(cmt_valid), .cmt_addr(cmt_addr), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic        clr;
    logic [1:0]  rv;
    logic [4:0]  ra0, ra1;
    logic        renv;
    logic [4:0]  rena;
    logic [3:0]  rent;
    logic [1:0]  cv;
    logic [4:0]  ca0;
    logic [3:0]  ct0;
    logic [31:0] cd0;
    logic [4:0]  ca1;
    logic [3:0]  ct1;
    logic [31:0] cd1;
    logic        er0;
    logic [31:0] ed0;
    logic [3:0]  et0;
    logic        er1;
    logic [31:0] ed1;
    logic [3:0]  et1;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
      input int rdy_i, input int clr_i, input int rv_i, input int ra0_i, input int ra1_i,
      input int renv_i, input int rena_i, input int rent_i,
      input int cv_i, input int ca0_i, input int ct0_i, input int cd0_i,
      input int ca1_i, input int ct1_i, input int cd1_i,
      input int er0_i, input int ed0_i, input int et0_i,
      input int er1_i, input int ed1_i, input int et1_i);
    vec_t v;
    v.rdy  = 1'(rdy_i);  v.clr  = 1'(clr_i);  v.rv  = 2'(rv_i);
    v.ra0  = 5'(ra0_i);  v.ra1  = 5'(ra1_i);
    v.renv = 1'(renv_i); v.rena = 5'(rena_i); v.rent = 4'(rent_i);
    v.cv   = 2'(cv_i);
    v.ca0  = 5'(ca0_i);  v.ct0  = 4'(ct0_i);  v.cd0 = 32'(cd0_i);
    v.ca1  = 5'(ca1_i);  v.ct1  = 4'(ct1_i);  v.cd1 = 32'(cd1_i);
    v.er0  = 1'(er0_i);  v.ed0  = 32'(ed0_i); v.et0 = 4'(et0_i);
    v.er1  = 1'(er1_i);  v.ed1  = 32'(ed1_i); v.et1 = 4'(et1_i);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; clear = 1'b0; rd_valid = '0; rd_addr = '0;
    ren_valid = 1'b0; ren_addr = '0; ren_tag = '0;
    cmt_valid = '0; cmt_addr = '0; cmt_tag = '0; cmt_data = '0;
    ckpt_save = 1'b0; ckpt_save_id = '0; ckpt_restore = 1'b0; ckpt_restore_id = '0;
  endtask

  task automatic check_port(input string pfx, input int p, input logic er,
                            input logic [31:0] ed, input logic [3:0] et);
    chk($sformatf("%s_p%0d_ready", pfx, p), 32'(rd_ready[p]), 32'(er));
    chk($sformatf("%s_p%0d_data", pfx, p), rd_data[p*32 +: 32], ed);
    chk($sformatf("%s_p%0d_tag", pfx, p), 32'(rd_tag[p*4 +: 4]), 32'(et));
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    idle_inputs();
    rdy = v.rdy; clear = v.clr; rd_valid = v.rv; rd_addr = {v.ra1, v.ra0};
    ren_valid = v.renv; ren_addr = v.rena; ren_tag = v.rent;
    cmt_valid = v.cv; cmt_addr = {v.ca1, v.ca0}; cmt_tag = {v.ct1, v.ct0};
    cmt_data = {v.cd1, v.cd0};
    #1;
    $display("vec %0d: rd0 x%0d -> r=%0b d=%h t=%0d | rd1 x%0d -> r=%0b d=%h t=%0d",
             idx, v.ra0, rd_ready[0], rd_data[31:0], rd_tag[3:0],
             v.ra1, rd_ready[1], rd_data[63:32], rd_tag[7:4]);
    check_port($sformatf("v%0d", idx), 0, v.er0, v.ed0, v.et0);
    check_port($sformatf("v%0d", idx), 1, v.er1, v.ed1, v.et1);
  endtask

  // Drive a plain two-port read (no other activity) and check it.
  task automatic read2(input string nm, input int a0, input int a1,
                       input logic e0r, input logic [31:0] e0d, input logic [3:0] e0t,
                       input logic e1r, input logic [31:0] e1d, input logic [3:0] e1t);
    rd_valid = 2'b11; rd_addr = {5'(a1), 5'(a0)};
    #1;
    $display("%s: x%0d r=%0b d=%h t=%0d | x%0d r=%0b d=%h t=%0d", nm,
             a0, rd_ready[0], rd_data[31:0], rd_tag[3:0],
             a1, rd_ready[1], rd_data[63:32], rd_tag[7:4]);
    check_port(nm, 0, e0r, e0d, e0t);
    check_port(nm, 1, e1r, e1d, e1t);
  endtask

  initial begin
    // rdy clr rv ra0 ra1 | renv rena rent | cv ca0 ct0 cd0 ca1 ct1 cd1 | er0 ed0 et0 er1 ed1 et1
    vecs[0]  = mk(1,0,3, 5,0,  0,0,0, 0, 0,0,0, 0,0,0,  1,0,0, 1,0,0);
    vecs[1]  = mk(1,0,3, 3,0,  1,3,7, 0, 0,0,0, 0,0,0,  1,0,0, 1,0,0);
    vecs[2]  = mk(1,0,1, 3,0,  0,0,0, 0, 0,0,0, 0,0,0,  0,0,7, 0,0,0);
    vecs[3]  = mk(1,0,3, 3,3,  0,0,0, 1, 3,7,32'hDEADBEEF, 0,0,0,
                  1,32'hDEADBEEF,0, 1,32'hDEADBEEF,0);
    vecs[4]  = mk(1,0,3, 3,4,  1,4,2, 0, 0,0,0, 0,0,0,  1,32'hDEADBEEF,7, 1,0,0);
    vecs[5]  = mk(1,0,1, 4,0,  1,4,5, 0, 0,0,0, 0,0,0,  0,0,2, 0,0,0);
    vecs[6]  = mk(1,0,1, 4,0,  0,0,0, 2, 0,0,0, 4,2,32'h11,  0,0,5, 0,0,0);
    vecs[7]  = mk(1,0,1, 4,0,  0,0,0, 0, 0,0,0, 0,0,0,  0,32'h11,5, 0,0,0);
    vecs[8]  = mk(1,0,1, 4,0,  0,0,0, 1, 4,5,32'h22, 0,0,0,  1,32'h22,0, 0,0,0);
    vecs[9]  = mk(1,0,1, 4,0,  0,0,0, 0, 0,0,0, 0,0,0,  1,32'h22,5, 0,0,0);
    vecs[10] = mk(1,0,0, 0,0,  1,6,2, 0, 0,0,0, 0,0,0,  0,0,0, 0,0,0);
    vecs[11] = mk(1,0,3, 6,6,  0,0,0, 3, 6,1,32'hA, 6,2,32'hB,  1,32'hB,0, 1,32'hB,0);
    vecs[12] = mk(1,0,1, 6,0,  0,0,0, 0, 0,0,0, 0,0,0,  1,32'hB,2, 0,0,0);
    vecs[13] = mk(1,0,0, 0,0,  1,6,3, 3, 6,1,32'hC, 6,2,32'hD,  0,0,0, 0,0,0);
    vecs[14] = mk(1,0,1, 6,0,  0,0,0, 0, 0,0,0, 0,0,0,  0,32'hD,3, 0,0,0);
    vecs[15] = mk(1,0,0, 0,0,  1,7,8, 0, 0,0,0, 0,0,0,  0,0,0, 0,0,0);
    vecs[16] = mk(1,0,0, 0,0,  1,8,9, 0, 0,0,0, 0,0,0,  0,0,0, 0,0,0);
    vecs[17] = mk(1,1,3, 7,8,  1,10,1, 1, 8,0,32'h55, 0,0,0,  0,0,8, 0,0,9);
    vecs[18] = mk(1,0,3, 8,7,  0,0,0, 0, 0,0,0, 0,0,0,  1,32'h55,0, 1,0,0);
    vecs[19] = mk(1,0,3, 6,10, 0,0,0, 0, 0,0,0, 0,0,0,  1,32'hD,0, 1,0,0);
    vecs[20] = mk(0,0,3, 6,9,  1,9,4, 1, 9,0,32'h99, 0,0,0,  1,32'hD,0, 1,32'h99,0);
    vecs[21] = mk(1,0,1, 9,0,  0,0,0, 0, 0,0,0, 0,0,0,  1,0,0, 0,0,0);
    vecs[22] = mk(1,0,1, 0,0,  1,0,3, 1, 0,0,32'h77, 0,0,0,  1,0,0, 0,0,0);
    vecs[23] = mk(1,0,3, 0,3,  0,0,0, 0, 0,0,0, 0,0,0,  1,0,0, 1,32'hDEADBEEF,0);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Outputs are forced to zero while reset is held, even for a valid read.
    read2("in_reset", 5, 0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i);

    // Asynchronous reset mid-run: outputs drop immediately, state is wiped.
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    read2("async_rst", 3, 6, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    read2("after_rst", 3, 6, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0, 4'h0);

`ifdef RRF_CKPT_EN
    // c1: rename x10 tag 4; commit x11 (tag 0) value 0x1234.
    @(negedge clk); idle_inputs();
    ren_valid = 1'b1; ren_addr = 5'd10; ren_tag = 4'd4;
    cmt_valid = 2'b01; cmt_addr = {5'd0, 5'd11}; cmt_tag = 8'h00; cmt_data = {32'h0, 32'h1234};
    // c2: save slot 1.
    @(negedge clk); idle_inputs();
    ckpt_save = 1'b1; ckpt_save_id = 2'd1;
    read2("ck_saved", 10, 11, 1'b0, 32'h0, 4'd4, 1'b1, 32'h1234, 4'd0);
    // c3: rename x11 tag 6.
    @(negedge clk); idle_inputs();
    ren_valid = 1'b1; ren_addr = 5'd11; ren_tag = 4'd6;
    // c4: commit x10 tag 4 value 0xAB.
    @(negedge clk); idle_inputs();
    read2("ck_renamed", 11, 11, 1'b0, 32'h1234, 4'd6, 1'b0, 32'h1234, 4'd6);
    cmt_valid = 2'b01; cmt_addr = {5'd0, 5'd10}; cmt_tag = {4'd0, 4'd4}; cmt_data = {32'h0, 32'hAB};
    // c5: restore slot 1.
    @(negedge clk); idle_inputs();
    ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
    // c6: x10 retired in the slot, x11 back to its pre-rename state.
    @(negedge clk); idle_inputs();
    read2("ck_restored", 10, 11, 1'b1, 32'hAB, 4'd4, 1'b1, 32'h1234, 4'd0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Parametrised architectural register file with rename-tag/busy tracking for the Tomasulo/ROB out-of-order core.
- Sits between decode/dispatch and the ROB commit stage.
- Serves NUM_READ combinational operand lookups per cycle, with commit bypass.
- Accepts one rename per cycle and NUM_COMMIT in-order ROB commits per cycle; flushes rename state on mispredict.

Parameters:
- NUM_REGS, 32, architectural register count; reg 0 is hardwired zero.
- REG_W, 5, register address width; must be at least clog2(NUM_REGS).
- DATA_W, 32, register data width.
- TAG_W, 4, ROB reorder tag width.
- NUM_READ, 2, number of operand read ports.
- NUM_COMMIT, 2, number of ROB commit ports. Index 0 is the oldest instruction.
- CKPT_DEPTH, 4, checkpoint slots; used only with RRF_CKPT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- rdy  in  1  global enable; when low, state holds.
- clear  in  1  synchronous flush of rename state.
- rd_valid  in  NUM_READ  per-port lookup request.
- rd_addr  in  NUM_READ*REG_W  per-port register address; port k occupies slice k.
- rd_ready  out  NUM_READ  operand value is available.
- rd_data  out  NUM_READ*DATA_W  operand value.
- rd_tag  out  NUM_READ*TAG_W  producer ROB tag; meaningful only when rd_ready=0.
- ren_valid  in  1  dispatch renames a destination this cycle.
- ren_addr  in  REG_W  destination register.
- ren_tag  in  TAG_W  ROB tag assigned to the destination.
- cmt_valid  in  NUM_COMMIT  per-port commit strobe.
- cmt_addr  in  NUM_COMMIT*REG_W  committed destination register.
- cmt_tag  in  NUM_COMMIT*TAG_W  committed ROB tag.
- cmt_data  in  NUM_COMMIT*DATA_W  committed value.
- ckpt_save  in  1  snapshot request (RRF_CKPT_EN only).
- ckpt_save_id  in  clog2(CKPT_DEPTH)  destination slot (RRF_CKPT_EN only).
- ckpt_restore  in  1  restore request (RRF_CKPT_EN only).
- ckpt_restore_id  in  clog2(CKPT_DEPTH)  source slot (RRF_CKPT_EN only).

Behaviour:
- State: regs[NUM_REGS], tags[NUM_REGS], busy[NUM_REGS].
- rst (async): regs=0, tags=0, busy=0, all checkpoint slots=0. While rst is high, all read outputs are 0.
- Read path is combinational and zero-latency. For each port k, the first matching rule applies:
  - rst → ready 0, data 0, tag 0.
  - rd_valid[k]=0 → ready 0, data 0, tag 0.
  - addr=0 → ready 1, data 0, tag 0.
  - A commit port c has cmt_valid, cmt_addr=addr and cmt_tag=tags[addr] → ready 1, data=cmt_data[c], tag 0. If several ports match, the highest c wins.
  - Otherwise → ready=~busy[addr], data=regs[addr], tag=tags[addr].
- Reads never observe a same-cycle rename. Dispatch reads sources before its own destination rename.
- Commit (rdy=1), for each valid port with addr≠0:
  - regs[addr] <= data.
  - busy[addr] <= 0 only if cmt_tag equals the pre-edge tags[addr].
  - Two ports writing the same addr in one cycle: the higher index wins both data and busy.
- Rename (rdy=1, ren_valid, addr≠0): tags <= ren_tag, busy <= 1.
  - Rename overrides a same-cycle busy clear on the same addr; the commit data is still written.
  - A rename to addr 0 is ignored.
- clear (rdy=1): busy <= 0 and tags <= 0 for all registers.
  - Same-cycle rename is discarded.
  - Same-cycle commits still write regs, because they are architectural.
  - clear has priority over restore and save.
- rdy=0: no state change; reads remain live on the current state.
- Reg 0 is never busy and always reads 0, regardless of commit, rename or restore.

Optional Feature:
- Macro: RRF_CKPT_EN.
- Defined: adds CKPT_DEPTH snapshots of tags/busy (data is not snapshotted).
  - ckpt_save writes the post-edge next-state tags/busy, including same-cycle rename and commit, into slot ckpt_save_id.
  - Every commit also clears busy in each slot whose stored tag for that addr matches cmt_tag.
  - ckpt_restore loads tags/busy from the slot, then applies same-cycle commit clears. Same-cycle rename is discarded.
  - Save and restore in the same cycle: restore applies; the save writes the restored state.
- Undefined: no checkpoint storage is built; ckpt_* inputs are ignored; only clear recovers rename state.

Test Plan:
- Reset state: rst pulse, then read x5 → ready 1, data 0. Read x0 with rd_valid=1 → ready 1, data 0.
- Rename then commit: rename x3 tag 7; next cycle read x3 → ready 0, tag 7. Commit x3 tag 7 data 0xDEADBEEF → same-cycle read x3 gives ready 1, data 0xDEADBEEF; following cycle reads regs, busy 0.
- Stale tag: rename x4 tag 2, then rename x4 tag 5. Commit x4 tag 2 data 0x11 → regs[x4]=0x11 but busy stays 1, read tag 5. Commit tag 5 data 0x22 → ready 1, data 0x22.
- Dual commit and collision: commit ports 0 and 1 both target x6 (tags 1 and 2, tags[x6]=2, data 0xA / 0xB) → regs[x6]=0xB, busy 0. Same-cycle rename x6 tag 3 → busy 1, tag 3.
- Flush: three registers busy; assert clear together with commit x8 data 0x55 → all ready 1, x8 reads 0x55. Hold rdy=0 with rename x9 → x9 not busy.
- Checkpoint (RRF_CKPT_EN): save slot 1 with x10 busy tag 4; rename x11 tag 6; commit x10 tag 4; restore slot 1 → x10 ready, x11 ready with its pre-rename value.
